// File: rtl/prandom_pkg.sv
// Shared constants and helpers for the prandom LFSR.
// Tap masks use bit i = state bit i XORed into the feedback.
package prandom_pkg;

  localparam int         PRANDOM_WIDTH = 3;
  localparam logic [2:0] PRANDOM_SEED  = 3'b001;
  localparam logic [2:0] PRANDOM_TAPS  = 3'b110;

  // Maximal-length masks for a left-shifting Fibonacci LFSR
  function automatic logic [31:0] prandom_taps(input int unsigned width);
    logic [31:0] t;
    t = '0;
    case (width)
      2:  t = 32'h0000_0003;
      3:  t = 32'h0000_0006;
      4:  t = 32'h0000_000C;
      5:  t = 32'h0000_0014;
      6:  t = 32'h0000_0030;
      7:  t = 32'h0000_0060;
      8:  t = 32'h0000_00B8;
      9:  t = 32'h0000_0110;
      10: t = 32'h0000_0240;
      11: t = 32'h0000_0500;
      12: t = 32'h0000_0829;
      13: t = 32'h0000_100D;
      14: t = 32'h0000_2015;
      15: t = 32'h0000_6000;
      16: t = 32'h0000_D008;
      17: t = 32'h0001_2000;
      18: t = 32'h0002_0400;
      19: t = 32'h0004_0023;
      20: t = 32'h0009_0000;
      21: t = 32'h0014_0000;
      22: t = 32'h0030_0000;
      23: t = 32'h0042_0000;
      24: t = 32'h00E1_0000;
      25: t = 32'h0120_0000;
      26: t = 32'h0200_0023;
      27: t = 32'h0400_0013;
      28: t = 32'h0900_0000;
      29: t = 32'h1400_0000;
      30: t = 32'h2000_0029;
      31: t = 32'h4800_0000;
      32: t = 32'h8020_0003;
      default: t = '0;
    endcase
    return t;
  endfunction

  function automatic logic [31:0] lfsr_next(
    input logic [31:0] state,
    input logic [31:0] taps
  );
    return {state[30:0], ^(state & taps)};
  endfunction

endpackage

// File: rtl/prandom_lfsr.sv
// Free-running Fibonacci LFSR; Q comes straight from the state flops.
// An all-zero state reloads the seed rather than locking up.
module prandom_lfsr
  import prandom_pkg::*;
#(
  parameter int               WIDTH = PRANDOM_WIDTH,
  parameter logic [WIDTH-1:0] SEED  = WIDTH'(PRANDOM_SEED),
  parameter logic [WIDTH-1:0] TAPS  = WIDTH'(PRANDOM_TAPS)
) (
  input  logic             clk,
  input  logic             rst,
  output logic [WIDTH-1:0] Q
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] SEED_EFF = (SEED == '0) ? ONE : SEED;

  if (WIDTH < 2 || WIDTH > 32) begin : g_width_chk
    $fatal(1, "prandom_lfsr: WIDTH must be 2..32");
  end

  if (TAPS == '0) begin : g_taps_chk
    $fatal(1, "prandom_lfsr: TAPS must be non-zero");
  end

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;

  always_comb begin
    q_d = WIDTH'(lfsr_next(32'(q_q), 32'(TAPS)));
    if (q_q == '0) begin
      q_d = SEED_EFF;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q <= SEED_EFF;
    end else begin
      q_q <= q_d;
    end
  end

  assign Q = q_q;

endmodule

// File: tb/tb_prandom_lfsr.sv
// Scoreboard bench for prandom_lfsr: default 3-bit and a 4-bit instance.
// Stimulus queues hand-computed expectations; a monitor pops and compares.
module tb_prandom_lfsr;

  logic       clk;
  logic       rst;
  logic       rst4;
  logic [2:0] q3;
  logic [3:0] q4;

  prandom_lfsr dut3 (
    .clk (clk),
    .rst (rst),
    .Q   (q3)
  );

  prandom_lfsr #(
    .WIDTH (4),
    .SEED  (4'b0001),
    .TAPS  (4'b1100)
  ) dut4 (
    .clk (clk),
    .rst (rst4),
    .Q   (q4)
  );

  typedef struct {
    string      name;
    bit         wide;
    logic [3:0] exp;
  } exp_t;

  exp_t queue_q[$];
  event chk_ev;
  int   n_total;
  int   n_pass;

  logic [2:0] seq3 [7];
  logic [3:0] seq4 [15];

  initial begin
    clk = 1'b1;
    forever #10 clk = ~clk;
  end

  task automatic expect3(input string nm, input logic [2:0] v);
    exp_t e;
    e.name = nm;
    e.wide = 1'b0;
    e.exp  = {1'b0, v};
    queue_q.push_back(e);
  endtask

  task automatic expect4(input string nm, input logic [3:0] v);
    exp_t e;
    e.name = nm;
    e.wide = 1'b1;
    e.exp  = v;
    queue_q.push_back(e);
  endtask

  task automatic strobe();
    -> chk_ev;
    #1;
  endtask

  task automatic edge_sample();
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare every queued expectation against the live outputs
  initial begin
    exp_t       e;
    logic [3:0] act;
    forever begin
      @(chk_ev);
      while (queue_q.size() > 0) begin
        e   = queue_q.pop_front();
        act = e.wide ? q4 : {1'b0, q3};
        n_total++;
        if (act === e.exp) begin
          n_pass++;
        end else begin
          $display("FAIL %s: got %b expected %b", e.name, act, e.exp);
        end
      end
    end
  end

  initial begin
    n_total = 0;
    n_pass  = 0;
    seq3 = '{3'b001, 3'b010, 3'b101, 3'b011, 3'b111, 3'b110, 3'b100};
    seq4 = '{4'b0001, 4'b0010, 4'b0100, 4'b1001, 4'b0011,
             4'b0110, 4'b1101, 4'b1010, 4'b0101, 4'b1011,
             4'b0111, 4'b1111, 4'b1110, 4'b1100, 4'b1000};
    rst  = 1'b1;
    rst4 = 1'b1;

    #1;
    expect3("reset_q3", 3'b001);
    expect4("reset_q4", 4'b0001);
    strobe();

    #3;
    rst  = 1'b0;
    rst4 = 1'b0;
    #1;
    expect3("release_q3", 3'b001);
    strobe();

    for (int i = 1; i <= 15; i++) begin
      edge_sample();
      expect3($sformatf("seq3_edge%0d", i), seq3[i % 7]);
      expect4($sformatf("seq4_edge%0d", i), seq4[i % 15]);
      strobe();
    end

    for (int i = 16; i <= 18; i++) begin
      edge_sample();
      expect3($sformatf("seq3_edge%0d", i), seq3[i % 7]);
      strobe();
    end

    // Mid-cycle async reset while Q=111
    #3;
    rst = 1'b1;
    #1;
    expect3("async_reset", 3'b001);
    strobe();

    edge_sample();
    expect3("edge_during_reset", 3'b001);
    strobe();

    #3;
    rst = 1'b0;
    edge_sample();
    expect3("after_reset_edge", 3'b010);
    strobe();

    // Lock-up recovery from a deposited all-zero state
    #13;
    dut3.q_q = 3'b000;
    #1;
    expect3("deposit_zero", 3'b000);
    strobe();

    edge_sample();
    expect3("lockup_reload", 3'b001);
    strobe();

    edge_sample();
    expect3("resume_1", 3'b010);
    strobe();

    edge_sample();
    expect3("resume_2", 3'b101);
    strobe();

    #2;
    if (queue_q.size() != 0) begin
      n_total++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0",
               queue_q.size());
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
